decode_issue_ctrl: RTL and testbench

- Decode-stage front controller between instruction fetch and the immediate extender / register-file read.
- Accepts fetched instructions over a valid/ready handshake and classifies each opcode into the TYPE code consumed by the immediate extender.
- Buffers up to two decoded entries in a skid queue and issues them downstream under backpressure.
- Handles pipeline flush, illegal-opcode flagging and a saturating issue counter.

---
 rtl/decode_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// decode_issue_ctrl
//
// Decode-stage front controller. Accepts fetched instructions over a
// valid/ready handshake, classifies each opcode into the TYPE code used by the
// immediate extender, and buffers up to two decoded entries in a skid queue.
// The head entry is issued downstream under backpressure. A synchronous flush
// empties the queue, and a saturating counter tracks issued instructions.
//
// Ports:
//   CLK          in   clock, all state updates on the rising edge
//   RSTN         in   asynchronous active-low reset
//   IN_VALID     in   fetch presents an instruction
//   IN_INS[31:0] in   fetched instruction word
//   IN_PC[31:0]  in   PC of IN_INS
//   IN_READY     out  queue has room (registered count only)
//   OUT_VALID    out  head entry valid
//   OUT_READY    in   downstream consumes the head this cycle
//   OUT_INS      out  head instruction word
//   OUT_PC       out  head PC
//   OUT_TYPE     out  head TYPE code (NONE when the queue is empty)
//   OUT_ILLEGAL  out  head opcode unrecognised (0 when the queue is empty)
//   FLUSH        in   synchronous flush from branch/jump resolution
//   ISSUE_CNT    out  saturating count of issued instructions
// -----------------------------------------------------------------------------
module decode_issue_ctrl #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             IN_VALID,
  input  logic [31:0]      IN_INS,
  input  logic [31:0]      IN_PC,
  output logic             IN_READY,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_INS,
  output logic [31:0]      OUT_PC,
  output logic [2:0]       OUT_TYPE,
  output logic             OUT_ILLEGAL,
  input  logic             FLUSH,
  output logic [CNT_W-1:0] ISSUE_CNT
);

  typedef enum logic [2:0] {
    TYPE_R    = 3'd0,
    TYPE_I    = 3'd1,
    TYPE_S    = 3'd2,
    TYPE_B    = 3'd3,
    TYPE_U    = 3'd4,
    TYPE_J    = 3'd5,
    TYPE_NONE = 3'd7
  } ins_type_e;

  // Queue storage; pointers are one bit because only two entries exist.
  logic [31:0] ins_q     [DEPTH];
  logic [31:0] pc_q      [DEPTH];
  ins_type_e   type_q    [DEPTH];
  logic        illegal_q [DEPTH];

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q,  count_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

  ins_type_e  dec_type;
  logic       dec_illegal;
  logic       push;
  logic       pop;

  // ---------------------------------------------------------------------------
  // Opcode classification
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    dec_type = TYPE_NONE;
    unique case (IN_INS[6:0])
      7'b0110011:                                     dec_type = TYPE_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b0001111, 7'b1110011:                         dec_type = TYPE_I;
      7'b0100011:                                     dec_type = TYPE_S;
      7'b1100011:                                     dec_type = TYPE_B;
      7'b0110111, 7'b0010111:                         dec_type = TYPE_U;
      7'b1101111:                                     dec_type = TYPE_J;
      default:                                        dec_type = TYPE_NONE;
    endcase
  end

  assign dec_illegal = (dec_type == TYPE_NONE);

  // ---------------------------------------------------------------------------
  // Handshake: both readies come from registered count only, so there is no
  // combinational path from OUT_READY to IN_READY.
  // ---------------------------------------------------------------------------
  assign IN_READY  = (count_q != 2'd2);
  assign OUT_VALID = (count_q != 2'd0);
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    issue_cnt_d = issue_cnt_q;

    if (FLUSH) begin
      // Same-cycle push/pop are discarded; the issue counter is kept.
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      if (pop && (issue_cnt_q != {CNT_W{1'b1}})) begin
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      issue_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset. Its contents only
  // matter while count is non-zero, and the outputs below mask TYPE/ILLEGAL
  // when the queue is empty, so a reset here would only cost flops.
  always_ff @(posedge CLK) begin
    if (push && !FLUSH) begin
      ins_q[wr_ptr_q]     <= IN_INS;
      pc_q[wr_ptr_q]      <= IN_PC;
      type_q[wr_ptr_q]    <= dec_type;
      illegal_q[wr_ptr_q] <= dec_illegal;
    end
  end

  // ---------------------------------------------------------------------------
  // Head outputs
  // ---------------------------------------------------------------------------
  assign OUT_INS     = ins_q[rd_ptr_q];
  assign OUT_PC      = pc_q[rd_ptr_q];
  assign OUT_TYPE    = OUT_VALID ? type_q[rd_ptr_q] : TYPE_NONE;
  assign OUT_ILLEGAL = OUT_VALID & illegal_q[rd_ptr_q];
  assign ISSUE_CNT   = issue_cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decode_issue_ctrl
//
// Self-checking bench for decode_issue_ctrl. A queue-based reference model
// tracks the entries the controller should hold and the number of pops since
// reset. A second instance with a 4-bit counter shares all inputs so counter
// saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_ins;
  logic [31:0] in_pc;
  logic        out_ready;
  logic        flush;

  logic        in_ready,  out_valid,  out_illegal;
  logic [31:0] out_ins,   out_pc;
  logic [2:0]  out_type;
  logic [15:0] issue_cnt;

  logic        s_in_ready, s_out_valid, s_out_illegal;
  logic [31:0] s_out_ins,  s_out_pc;
  logic [2:0]  s_out_type;
  logic [3:0]  s_issue_cnt;

  always #5 clk = ~clk;

  decode_issue_ctrl #(.DEPTH(2), .CNT_W(16)) dut (
    .CLK(clk), .RSTN(rst_n),
    .IN_VALID(in_valid), .IN_INS(in_ins), .IN_PC(in_pc), .IN_READY(in_ready),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_INS(out_ins),
    .OUT_PC(out_pc), .OUT_TYPE(out_type), .OUT_ILLEGAL(out_illegal),
    .FLUSH(flush), .ISSUE_CNT(issue_cnt)
  );

  decode_issue_ctrl #(.DEPTH(2), .CNT_W(4)) dut_sat (
    .CLK(clk), .RSTN(rst_n),
    .IN_VALID(in_valid), .IN_INS(in_ins), .IN_PC(in_pc), .IN_READY(s_in_ready),
    .OUT_VALID(s_out_valid), .OUT_READY(out_ready), .OUT_INS(s_out_ins),
    .OUT_PC(s_out_pc), .OUT_TYPE(s_out_type), .OUT_ILLEGAL(s_out_illegal),
    .FLUSH(flush), .ISSUE_CNT(s_issue_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  int unsigned pops;

  function automatic logic [2:0] ref_type(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'h33)                                   return 3'd0;
    if (op == 7'h13 || op == 7'h03 || op == 7'h67 ||
        op == 7'h0F || op == 7'h73)                    return 3'd1;
    if (op == 7'h23)                                   return 3'd2;
    if (op == 7'h63)                                   return 3'd3;
    if (op == 7'h37 || op == 7'h17)                    return 3'd4;
    if (op == 7'h6F)                                   return 3'd5;
    return 3'd7;
  endfunction

  task automatic check_outputs(input string tag);
    int unsigned exp16, exp4;
    ent_t h;
    exp16 = (pops > 65535) ? 65535 : pops;
    exp4  = (pops > 15) ? 15 : pops;
    check({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      check({tag, ".ins"},     64'(out_ins),     64'(h.ins));
      check({tag, ".pc"},      64'(out_pc),      64'(h.pc));
      check({tag, ".type"},    64'(out_type),    64'(ref_type(h.ins)));
      check({tag, ".illegal"}, 64'(out_illegal), 64'(ref_type(h.ins) == 3'd7));
    end else begin
      check({tag, ".type"},    64'(out_type),    64'd7);
      check({tag, ".illegal"}, 64'(out_illegal), 64'd0);
    end
    check({tag, ".cnt"},     64'(issue_cnt),   64'(exp16));
    check({tag, ".cnt_sat"}, 64'(s_issue_cnt), 64'(exp4));
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then apply
  // the model update at the rising edge.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic ordy, input logic fl);
    bit do_push, do_pop;
    ent_t e;
    in_valid  = v;
    in_ins    = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs(tag);
    do_push = v && (mq.size() < 2);
    do_pop  = ordy && (mq.size() != 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) begin
        void'(mq.pop_front());
        pops++;
      end
      if (do_push) begin
        e.ins = ins;
        e.pc  = pc;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  logic [6:0] legal_ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F,
                                 7'h73, 7'h23, 7'h63, 7'h37, 7'h6F};

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    if ($urandom_range(0, 4) == 0) op = r[6:0];
    else                           op = legal_ops[$urandom_range(0, 9)];
    return {r[31:7], op};
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ins = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0; pops = 0;

    // Reset held with random inputs.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom);
      in_ins    = rand_ins();
      in_pc     = $urandom;
      out_ready = 1'($urandom);
      flush     = 1'($urandom);
      #1;
      check_outputs("reset");
      @(negedge clk);
    end
    rst_n = 1'b1;

    // Streaming with OUT_READY=1.
    step("str0", 1, 32'h00500093, 32'h100, 1, 0);
    step("str1", 1, 32'h00112023, 32'h104, 1, 0);
    step("str2", 1, 32'hFE000EE3, 32'h108, 1, 0);
    step("str3", 1, 32'h000012B7, 32'h10C, 1, 0);
    step("str4", 1, 32'h008000EF, 32'h110, 1, 0);
    step("str5", 0, 32'h0,        32'h0,   1, 0);
    step("str6", 0, 32'h0,        32'h0,   1, 0);
    check("stream_cnt", 64'(issue_cnt), 64'd5);

    // Backpressure: third instruction held while full, then drained in order.
    step("bp0", 1, 32'h00A00113, 32'h200, 0, 0);
    step("bp1", 1, 32'h00B00193, 32'h204, 0, 0);
    step("bp2", 1, 32'h00C00213, 32'h208, 0, 0);
    step("bp3", 1, 32'h00C00213, 32'h208, 1, 0);
    step("bp4", 1, 32'h00C00213, 32'h208, 1, 0);
    step("bp5", 0, 32'h0,        32'h0,   1, 0);
    step("bp6", 0, 32'h0,        32'h0,   1, 0);

    // Flush at count=2 with a push and a pop attempted in the same cycle.
    step("fl0", 1, 32'h00100093, 32'h300, 0, 0);
    step("fl1", 1, 32'h00200093, 32'h304, 0, 0);
    step("fl2", 1, 32'h00300093, 32'h308, 1, 1);
    step("fl3", 0, 32'h0,        32'h0,   0, 0);

    // Illegal opcode is queued and issued.
    step("ill0", 1, 32'h0000007F, 32'h400, 0, 0);
    step("ill1", 0, 32'h0,        32'h0,   1, 0);
    step("ill2", 0, 32'h0,        32'h0,   0, 0);

    // Asynchronous reset between edges with the queue full.
    step("ar0", 1, 32'h00400093, 32'h500, 0, 0);
    step("ar1", 1, 32'h00500093, 32'h504, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async.out_valid", 64'(out_valid), 64'd0);
    check("async.in_ready",  64'(in_ready),  64'd1);
    check("async.type",      64'(out_type),  64'd7);
    check("async.cnt",       64'(issue_cnt), 64'd0);
    mq.delete();
    pops = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic; the 4-bit instance saturates along the way.
    for (int i = 0; i < 600; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), rand_ins(), $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end
    check("sat_reached", 64'(pops > 15), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
